// File: rtl/mult_hilo_sequencer_if.sv
// mult_hilo_sequencer_if
//
// Purpose: bundles every non-clock signal of the HI/LO multiply sequencer.
// It covers the pipeline request channel, the direct HI/LO write port, the
// handshake with the 32-bit unsigned sequential multiplier, and the
// architectural HI/LO registers with their status strobes.
//
// Signal summary:
//   reqValid/reqReady     request handshake (accept on both high)
//   reqSigned, reqA, reqB request type and operands
//   hiWrite/loWrite       direct write strobes, hiIn/loIn their data
//   mulA, mulB, mulStart  operand magnitudes and start pulse to the multiplier
//   mulFinish, mulP       multiplier halt flag and unsigned 64-bit product
//   hi, lo                architectural HI/LO
//   busy, done, error     sequencer status
//
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding pipeline plus the multiplier
interface mult_hilo_sequencer_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqSigned;
  logic [31:0] reqA;
  logic [31:0] reqB;

  logic        hiWrite;
  logic        loWrite;
  logic [31:0] hiIn;
  logic [31:0] loIn;

  logic [31:0] mulA;
  logic [31:0] mulB;
  logic        mulStart;
  logic        mulFinish;
  logic [63:0] mulP;

  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        error;

  modport slave (
    input  reqValid, reqSigned, reqA, reqB,
    input  hiWrite, loWrite, hiIn, loIn,
    input  mulFinish, mulP,
    output reqReady,
    output mulA, mulB, mulStart,
    output hi, lo, busy, done, error
  );

  modport master (
    output reqValid, reqSigned, reqA, reqB,
    output hiWrite, loWrite, hiIn, loIn,
    output mulFinish, mulP,
    input  reqReady,
    input  mulA, mulB, mulStart,
    input  hi, lo, busy, done, error
  );
endinterface

// File: rtl/mult_hilo_sequencer.sv
// mult_hilo_sequencer
//
// Purpose: issue/writeback stage wrapped around a 32-bit unsigned sequential
// multiplier. It accepts signed or unsigned multiply requests and hands the
// operand magnitudes to the multiplier with a one-cycle start pulse. It then
// waits for the multiplier to finish, restores the product sign, and writes
// the 64-bit result into the architectural HI/LO registers. While idle it also
// accepts direct HI/LO writes. A watchdog aborts an operation with an error
// when the multiplier never finishes.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mult_hilo_sequencer_if.slave (request channel, direct writes,
//          multiplier handshake, hi/lo, busy/done/error)
//
// Parameter:
//   TIMEOUT  maximum number of cycles spent in ARM+WAIT before aborting
module mult_hilo_sequencer #(
  parameter int TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_hilo_sequencer_if.slave bus
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    FIX   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state;
  state_t nextState;

  // control strobes decoded by the next-state logic
  logic accept;
  logic clearCnt;
  logic incCnt;
  logic capture;
  logic writeResult;
  logic abort;

  // datapath registers
  logic          signReg;
  logic          timedOut;
  logic [31:0]   mulAReg;
  logic [31:0]   mulBReg;
  logic [63:0]   result;
  logic [31:0]   hiReg;
  logic [31:0]   loReg;
  logic [CW-1:0] toCnt;

  // combinational helpers
  logic          timeoutHit;
  logic [31:0]   magA;
  logic [31:0]   magB;
  logic [63:0]   fixedResult;

  // The negation of 0x8000_0000 wraps back to 0x8000_0000. That is the
  // correct unsigned magnitude, so no special case is needed.
  assign magA = (bus.reqSigned && bus.reqA[31]) ? (32'd0 - bus.reqA) : bus.reqA;
  assign magB = (bus.reqSigned && bus.reqB[31]) ? (32'd0 - bus.reqB) : bus.reqB;

  // The counter holds the number of ARM/WAIT cycles already spent. When it
  // shows TIMEOUT-1, the current cycle is the last one allowed.
  assign timeoutHit = (toCnt == TO_LAST);

  assign fixedResult = signReg ? (~result + 64'd1) : result;

  assign bus.mulA = mulAReg;
  assign bus.mulB = mulBReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Every handshake output is decoded from the state alone. Because of this,
  // reset drops mulStart and busy immediately, and reqReady never depends on
  // reqValid.
  always_comb begin
    nextState    = state;
    accept       = 1'b0;
    clearCnt     = 1'b0;
    incCnt       = 1'b0;
    capture      = 1'b0;
    writeResult  = 1'b0;
    abort        = 1'b0;
    bus.reqReady = 1'b0;
    bus.busy     = 1'b1;
    bus.mulStart = 1'b0;
    bus.done     = 1'b0;
    bus.error    = 1'b0;

    case (state)
      IDLE: begin
        bus.reqReady = 1'b1;
        bus.busy     = 1'b0;
        if (bus.reqValid) begin
          accept    = 1'b1;
          nextState = START;
        end
      end

      START: begin
        bus.mulStart = 1'b1;
        clearCnt     = 1'b1;
        nextState    = ARM;
      end

      // A finish flag left over from the previous operation must be seen to
      // drop before WAIT may trust it.
      ARM: begin
        incCnt = 1'b1;
        if (timeoutHit) begin
          abort     = 1'b1;
          nextState = DONE;
        end else if (!bus.mulFinish) begin
          nextState = WAIT;
        end
      end

      // A finish that arrives in the very last allowed cycle still wins over
      // the watchdog.
      WAIT: begin
        incCnt = 1'b1;
        if (bus.mulFinish) begin
          capture   = 1'b1;
          nextState = FIX;
        end else if (timeoutHit) begin
          abort     = 1'b1;
          nextState = DONE;
        end
      end

      FIX: begin
        writeResult = 1'b1;
        nextState   = DONE;
      end

      DONE: begin
        bus.done  = 1'b1;
        bus.error = timedOut;
        nextState = IDLE;
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Request latch: the result sign and the operand magnitudes. The operand
  // registers stay untouched until the next accept, so the multiplier sees
  // stable operands for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signReg <= 1'b0;
      mulAReg <= '0;
      mulBReg <= '0;
    end else if (accept) begin
      signReg <= bus.reqSigned & (bus.reqA[31] ^ bus.reqB[31]);
      mulAReg <= magA;
      mulBReg <= magB;
    end
  end

  // Watchdog counter and the sticky timeout flag that DONE reports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toCnt    <= '0;
      timedOut <= 1'b0;
    end else begin
      if (clearCnt) begin
        toCnt <= '0;
      end else if (incCnt) begin
        toCnt <= toCnt + CW'(1);
      end

      if (accept) begin
        timedOut <= 1'b0;
      end else if (abort) begin
        timedOut <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (capture) begin
      result <= bus.mulP;
    end
  end

  // HI/LO writeback. Direct writes are honoured only in IDLE, which is also
  // the accept cycle. The signed product written in FIX therefore overwrites
  // any direct write that arrived together with the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (writeResult) begin
      hiReg <= fixedResult[63:32];
      loReg <= fixedResult[31:0];
    end else if (state == IDLE) begin
      if (bus.hiWrite) begin
        hiReg <= bus.hiIn;
      end
      if (bus.loWrite) begin
        loReg <= bus.loIn;
      end
    end
  end

endmodule

// File: tb/tb_mult_hilo_sequencer.sv
// tb_mult_hilo_sequencer
//
// Purpose: self-checking bench for mult_hilo_sequencer.
//
// The stimulus process issues requests and direct writes. For each accepted
// request it pushes the expected HI/LO, error flag, accept-to-done latency and
// operand magnitudes into a scoreboard queue. A monitor pops and compares on
// every done pulse. A behavioural multiplier drives the finish/product side
// with a per-request finish profile: a stale-high period, a low period, or
// stuck low. Expected products come from plain signed/unsigned 64-bit
// arithmetic.
module tb_mult_hilo_sequencer;

  localparam int TIMEOUT = 40;

  logic clk;
  logic rst_n;

  mult_hilo_sequencer_if bus ();

  mult_hilo_sequencer #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned lowCycles;
    int unsigned staleCycles;
    bit          stuck;
  } mulcfg_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          latency;
    logic [31:0] magA;
    logic [31:0] magB;
    int          acceptCycle;
    string       tag;
  } expect_t;

  typedef enum {M_IDLE, M_STALE, M_LOW, M_STUCK} mphase_t;

  mulcfg_t     cfgQ[$];
  expect_t     sbQ[$];
  int          errors = 0;
  int          checks = 0;
  int          cycleCount = 0;
  logic [31:0] archHi = '0;
  logic [31:0] archLo = '0;
  logic [31:0] capA = '0;
  logic [31:0] capB = '0;

  initial begin
    forever begin
      @(posedge clk);
      cycleCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] refProduct(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [31:0] refMag(input logic sgn, input logic [31:0] v);
    longint sv;
    sv = longint'($signed(v));
    if (sgn && sv < 0) return 32'(-sv);
    return v;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'd1;
      default: return 32'($urandom());
    endcase
  endfunction

  // Behavioural multiplier. On a start pulse it first keeps finish high for
  // staleCycles, then holds it low for lowCycles, then raises it with the new
  // product. Until then mulP keeps the previous product, so an early capture
  // shows up as a wrong result.
  initial begin
    mphase_t     phase;
    mulcfg_t     c;
    int unsigned left;
    phase         = M_IDLE;
    left          = 0;
    c             = '{lowCycles: 5, staleCycles: 0, stuck: 1'b0};
    bus.mulFinish = 1'b1;
    bus.mulP      = '0;
    forever begin
      @(posedge clk);
      if (bus.mulStart === 1'b1) begin
        if (cfgQ.size() > 0) c = cfgQ.pop_front();
        else c = '{lowCycles: 5, staleCycles: 0, stuck: 1'b0};
        capA = bus.mulA;
        capB = bus.mulB;
        if (c.stuck) begin
          bus.mulFinish <= 1'b0;
          phase = M_STUCK;
        end else if (c.staleCycles != 0) begin
          left  = c.staleCycles;
          phase = M_STALE;
        end else begin
          bus.mulFinish <= 1'b0;
          left  = c.lowCycles - 1;
          phase = M_LOW;
        end
      end else begin
        case (phase)
          M_STALE: begin
            left--;
            if (left == 0) begin
              bus.mulFinish <= 1'b0;
              left  = c.lowCycles - 1;
              phase = M_LOW;
            end
          end
          M_LOW: begin
            if (left == 0) begin
              bus.mulFinish <= 1'b1;
              bus.mulP      <= {32'd0, capA} * {32'd0, capB};
              phase = M_IDLE;
            end else begin
              left--;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Scoreboard monitor: every done pulse must match the oldest outstanding
  // request.
  initial begin
    expect_t e;
    int      lat;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pending request", cycleCount);
        end else begin
          e   = sbQ.pop_front();
          lat = cycleCount - e.acceptCycle + 1;
          checkOutput({e.tag, "_hi"},      64'(bus.hi),    64'(e.hi));
          checkOutput({e.tag, "_lo"},      64'(bus.lo),    64'(e.lo));
          checkOutput({e.tag, "_error"},   64'(bus.error), 64'(e.err));
          checkOutput({e.tag, "_latency"}, 64'(lat),       64'(e.latency));
          checkOutput({e.tag, "_mulA"},    64'(capA),      64'(e.magA));
          checkOutput({e.tag, "_mulB"},    64'(capB),      64'(e.magB));
        end
      end
    end
  end

  // Waits for the request to be accepted, then registers the expected
  // outcome. The call returns one time step into the START cycle.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input int unsigned lowC, input int unsigned staleC, input bit stuck,
                               input logic dwHi, input logic dwLo,
                               input logic [31:0] hiD, input logic [31:0] loD, input string tag);
    int          guard;
    logic [63:0] p;
    expect_t     e;
    guard = 0;
    @(negedge clk);
    while (bus.reqReady !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (bus.reqReady !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_accept: got reqReady=%b after %0d cycles, expected 1", tag, bus.reqReady, guard);
      return;
    end
    bus.reqValid  = 1'b1;
    bus.reqSigned = sgn;
    bus.reqA      = a;
    bus.reqB      = b;
    bus.hiWrite   = dwHi;
    bus.loWrite   = dwLo;
    bus.hiIn      = hiD;
    bus.loIn      = loD;
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    bus.hiWrite  = 1'b0;
    bus.loWrite  = 1'b0;

    if (dwHi) archHi = hiD;
    if (dwLo) archLo = loD;
    if (!stuck) begin
      p      = refProduct(sgn, a, b);
      archHi = p[63:32];
      archLo = p[31:0];
    end
    cfgQ.push_back('{lowCycles: lowC, staleCycles: staleC, stuck: stuck});
    e.hi          = archHi;
    e.lo          = archLo;
    e.err         = stuck;
    // one START cycle, then ARM/WAIT, then the done cycle
    e.latency     = stuck ? (TIMEOUT + 2) : int'(lowC + staleC + 4);
    e.magA        = refMag(sgn, a);
    e.magB        = refMag(sgn, b);
    e.acceptCycle = cycleCount;
    e.tag         = tag;
    sbQ.push_back(e);
  endtask

  task automatic directWrite(input logic dwHi, input logic dwLo, input logic [31:0] hiD,
                             input logic [31:0] loD, input string tag);
    @(negedge clk);
    bus.hiWrite = dwHi;
    bus.loWrite = dwLo;
    bus.hiIn    = hiD;
    bus.loIn    = loD;
    @(posedge clk);
    #1;
    bus.hiWrite = 1'b0;
    bus.loWrite = 1'b0;
    if (dwHi) archHi = hiD;
    if (dwLo) archLo = loD;
    checkOutput({tag, "_hi"}, 64'(bus.hi), 64'(archHi));
    checkOutput({tag, "_lo"}, 64'(bus.lo), 64'(archLo));
  endtask

  task automatic waitIdle(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((sbQ.size() != 0 || bus.reqReady !== 1'b1) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (sbQ.size() != 0 || bus.reqReady !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_drain: got %0d pending requests, expected 0", tag, sbQ.size());
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        dw;

    rst_n         = 1'b0;
    bus.reqValid  = 1'b0;
    bus.reqSigned = 1'b0;
    bus.reqA      = '0;
    bus.reqB      = '0;
    bus.hiWrite   = 1'b0;
    bus.loWrite   = 1'b0;
    bus.hiIn      = '0;
    bus.loIn      = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_hi",       64'(bus.hi),       64'd0);
    checkOutput("rst_lo",       64'(bus.lo),       64'd0);
    checkOutput("rst_mulA",     64'(bus.mulA),     64'd0);
    checkOutput("rst_mulB",     64'(bus.mulB),     64'd0);
    checkOutput("rst_mulStart", 64'(bus.mulStart), 64'd0);
    checkOutput("rst_done",     64'(bus.done),     64'd0);
    checkOutput("rst_error",    64'(bus.error),    64'd0);
    checkOutput("rst_busy",     64'(bus.busy),     64'd0);
    checkOutput("rst_reqReady", 64'(bus.reqReady), 64'd1);
    rst_n = 1'b1;

    directWrite(1'b1, 1'b0, 32'h1234_5678, 32'h0, "dw_hi");
    directWrite(1'b0, 1'b1, 32'h0, 32'h9ABC_DEF0, "dw_lo");
    directWrite(1'b1, 1'b1, 32'hCAFE_0001, 32'hBEEF_0002, "dw_both");

    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, 1'b0, 1'b0, 1'b0, '0, '0, "umax");
    applyStimulus(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 10, 0, 1'b0, 1'b0, 1'b0, '0, '0, "neg3x7");
    applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 12, 0, 1'b0, 1'b0, 1'b0, '0, '0, "minxmin");
    applyStimulus(1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 4, 0, 1'b0, 1'b0, 1'b0, '0, '0, "neg5x0");
    applyStimulus(1'b0, 32'h8000_0000, 32'h0000_0003, 6, 0, 1'b0, 1'b0, 1'b0, '0, '0, "unsig_hibit");
    applyStimulus(1'b1, 32'h0001_2345, 32'h0006_789A, 8, 2, 1'b0, 1'b0, 1'b0, '0, '0, "stale");
    waitIdle("directed");

    // A multiplier stuck low aborts the operation. Direct writes during the
    // busy period must be dropped.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0000_0101, 1, 0, 1'b1, 1'b0, 1'b0, '0, '0, "timeout");
    repeat (10) begin
      @(negedge clk);
      bus.hiWrite = 1'b1;
      bus.loWrite = 1'b1;
      bus.hiIn    = 32'($urandom());
      bus.loIn    = 32'($urandom());
    end
    @(negedge clk);
    bus.hiWrite = 1'b0;
    bus.loWrite = 1'b0;
    waitIdle("timeout");
    checkOutput("after_timeout_hi", 64'(bus.hi), 64'(archHi));
    checkOutput("after_timeout_lo", 64'(bus.lo), 64'(archLo));

    applyStimulus(1'b0, 32'h0000_1000, 32'h0000_2000, 5, 0, 1'b0, 1'b1, 1'b1,
                  32'h1111_1111, 32'h2222_2222, "dw_with_accept");

    for (int i = 0; i < 16; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = pickOperand();
      b   = pickOperand();
      dw  = ($urandom_range(0, 3) == 0);
      applyStimulus(sgn, a, b, $urandom_range(1, 30), $urandom_range(0, 3), 1'b0,
                    dw, dw, 32'($urandom()), 32'($urandom()), $sformatf("rnd%0d", i));
    end
    waitIdle("random");

    // Asynchronous reset while in WAIT: abort with no done pulse.
    applyStimulus(1'b0, 32'h0000_0077, 32'h0000_0055, 20, 0, 1'b0, 1'b0, 1'b0, '0, '0, "rstwait");
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstwait_busy",     64'(bus.busy),     64'd0);
    checkOutput("rstwait_reqReady", 64'(bus.reqReady), 64'd1);
    checkOutput("rstwait_hi",       64'(bus.hi),       64'd0);
    checkOutput("rstwait_lo",       64'(bus.lo),       64'd0);
    checkOutput("rstwait_done",     64'(bus.done),     64'd0);
    sbQ.delete();
    cfgQ.delete();
    archHi = '0;
    archLo = '0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 32'hFFFF_FF00, 32'h0000_0300, 9, 0, 1'b0, 1'b0, 1'b0, '0, '0, "after_rst");
    waitIdle("after_rst");

    // Asynchronous reset during START: the start pulse must drop at once.
    applyStimulus(1'b0, 32'h0000_0009, 32'h0000_0009, 5, 0, 1'b0, 1'b0, 1'b0, '0, '0, "rststart");
    #1;
    checkOutput("rststart_pulse", 64'(bus.mulStart), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rststart_drop", 64'(bus.mulStart), 64'd0);
    checkOutput("rststart_busy", 64'(bus.busy),     64'd0);
    sbQ.delete();
    cfgQ.delete();
    archHi = '0;
    archLo = '0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 15, 1, 1'b0, 1'b0, 1'b0, '0, '0, "final");
    waitIdle("final");
    checkOutput("final_hi", 64'(bus.hi), 64'(archHi));
    checkOutput("final_lo", 64'(bus.lo), 64'(archLo));

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_hilo_sequencer.md
# mult_hilo_sequencer

Issue/writeback stage that sits directly upstream and downstream of the 32-bit unsigned sequential multiplier. It accepts signed or unsigned multiply requests and converts signed operands to magnitudes. It then pulses the multiplier's start input, waits for its finish, applies the result sign and writes the 64-bit product into architectural HI/LO registers. It also services direct HI/LO writes (move-to-HI/LO) and reports done/error to the pipeline.

## Interface
- TIMEOUT, 40, max cycles spent in ARM+WAIT before aborting with error.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- reqValid  in  1  multiply request present.
- reqReady  out  1  high only in IDLE; a request is accepted on reqValid&reqReady.
- reqSigned  in  1  1 = two's-complement operands, 0 = unsigned.
- reqA, reqB  in  32  operands.
- hiWrite, loWrite  in  1  direct write strobes (honoured only in IDLE).
- hiIn, loIn  in  32  direct write data.
- mulA, mulB  out  32  operand magnitudes to the multiplier (held stable from START until DONE).
- mulStart  out  1  one-cycle positive start pulse to the multiplier.
- mulFinish  in  1  multiplier halt flag.
- mulP  in  64  unsigned product from the multiplier.
- hi, lo  out  32  architectural HI/LO.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a request completes (good or error).
- error  out  1  one-cycle pulse with done when the request timed out.

## Operation
- States: IDLE, START, ARM, WAIT, FIX, DONE.
- IDLE: reqReady=1. On accept, latch sign = reqSigned & (reqA[31]^reqB[31]). Latch mulA = (reqSigned&reqA[31]) ? -reqA : reqA and mulB likewise, then go to START.
- Magnitude of 0x8000_0000 is 0x8000_0000 as unsigned 32-bit; no overflow special case.
- START: mulStart=1 for exactly this cycle; clear timeout counter; go to ARM.
- ARM: wait until mulFinish==0, so a stale finish from the previous operation is never consumed. Then go to WAIT.
- WAIT: on mulFinish==1, capture mulP into a 64-bit result register and go to FIX.
- FIX: result = sign ? (~result + 1) : result. Write hi = result[63:32] and lo = result[31:0]; go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- Timeout: the counter increments each cycle in ARM or WAIT. When it reaches TIMEOUT, go to DONE with error=1, leaving HI/LO unchanged.
- Direct writes: in IDLE, hiWrite loads hi ← hiIn and loWrite loads lo ← loIn. Both may assert in the same cycle.
- Direct writes outside IDLE are ignored (dropped, not queued).
- Simultaneous direct write and request accept in IDLE: the direct write takes effect that cycle. The multiply result later overwrites both HI and LO.
- Unsigned mode: sign forced 0; operands pass through unchanged.

## Timing
- Reset (async assert, sync to clk on release): state=IDLE; hi=lo=0; mulA=mulB=0; mulStart=0; done=error=0; busy=0; reqReady=1.
- Reset mid-operation: abort immediately; mulStart drops asynchronously; no done pulse. The multiplier's in-flight result is ignored after reset.
- Accept at edge k → START during cycle k+1 (mulStart high).
- Let the multiplier hold finish low for L cycles after start. WAIT captures at the first edge with mulFinish=1, FIX follows one cycle later, and done comes one cycle after that.
- Total accept-to-done = L + 4 cycles with a 1-cycle finish deassert. hi/lo are valid in the same cycle done is high and remain stable until the next write.
- Back-to-back: next request accepted in the cycle after DONE (IDLE), giving 1 idle bubble minimum.
- reqReady is combinational from state only; it never depends on reqValid.

## Test plan
- Unsigned 0xFFFF_FFFF × 0xFFFF_FFFF with model multiplier (finish low 33 cycles) → hi=0xFFFF_FFFE, lo=0x0000_0001; done exactly 37 cycles after accept; error=0.
- Signed −3 × 7 (0xFFFF_FFFD, 0x7) → mulA=3, mulB=7; hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
- Signed 0x8000_0000 × 0x8000_0000 → mulA=mulB=0x8000_0000; hi=0x4000_0000, lo=0; signed −5 × 0 → hi=lo=0.
- Stale finish: model holds finish=1 before start and drops it 2 cycles after mulStart → sequencer stays in ARM and does not capture early. Model stuck at finish=0 → done+error at TIMEOUT (40) cycles after START, hi/lo unchanged.
- Direct writes: hiWrite=1 with hiIn=0x1234_5678 and loWrite with loIn=0x9ABC_DEF0 in IDLE → registers updated next edge. Same strobes while busy → ignored. Strobe together with request accept → final hi/lo equal the product.
- Deassert rst_n in WAIT → immediate IDLE, hi=lo=0, no done. A new request after release completes normally.
